// File: rtl/if_stage.sv
// +----------------------------------------------------------------------+
// | if_stage : instruction fetch with one outstanding imem request        |
// | Rev 1.0  : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pause,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     inst_out,
  output logic            inst_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     buf_inst;
  logic [XLEN-1:0] buf_pc;
  logic            capture;
  logic            accept;

  assign imem_req_valid = (state == FETCH);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid = (state == HOLD);
  assign inst_out   = inst_valid ? buf_inst : NOP;
  assign pc_out     = inst_valid ? buf_pc : '0;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    case (state)
      FETCH: begin
        // An accepted request under redirect still has a response in flight.
        if (accept) state_next = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect) begin
            state_next = FETCH;
          end else begin
            state_next = HOLD;
            capture    = 1'b1;
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      HOLD: begin
        if (redirect || !pause) state_next = FETCH;
        if (!redirect && !pause) pc_next = pc + XLEN'(4);
      end
      DROP: begin
        if (imem_resp_valid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (redirect) pc_next = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      buf_inst <= NOP;
      buf_pc   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        buf_inst <= imem_resp_data;
        buf_pc   <= pc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +----------------------------------------------------------------------+
// | tb_if_stage : scoreboard bench for if_stage                           |
// | Rev 1.0  : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;
  int          mem_delay = 1;
  bit          use_override = 1'b0;
  logic [31:0] override_word = '0;

  if_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .pause          (pause),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .inst_valid     (inst_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_override ? override_word : {8'hA5, a[23:0]};
  endfunction

  // Advance one cycle; memory model answers mem_delay cycles after acceptance
  // and pushes the instruction it returns onto the scoreboard.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    logic        rst_s;
    acc   = imem_req_valid && imem_req_ready;
    a     = imem_addr;
    rst_s = reset;
    @(posedge clock);
    #1;
    imem_resp_valid = 1'b0;
    if (rst_s) begin
      pend = 1'b0;
    end else if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      cnt       = mem_delay;
    end
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        exp_q.push_back({pend_addr, imem_resp_data});
        pend = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    n_tests++;
    if (inst_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc=%h, want 0/%h/0", inst_valid, inst_out, pc_out, NOP);
    end
    reset = 1'b0;
    cycle();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1/%h", imem_req_valid, imem_addr, RST_PC);
    end
    n_tests++;
    if (inst_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: valid=%b inst=%h pc=%h", inst_valid, inst_out, pc_out);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    exp_t        e;
    exp_addr = 32'h0;
    mem_delay = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (inst_valid !== ((i % 3) == 2)) begin
        n_fail++;
        $display("FAIL stream_valid_c%0d: got %b want %b", i, inst_valid, ((i % 3) == 2));
      end
      if (imem_req_valid && imem_req_ready) begin
        n_tests++;
        if (imem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL stream_addr: got %h want %h", imem_addr, exp_addr);
        end
        exp_addr += 4;
      end
      if (inst_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_sb_empty: got pc %h want none", pc_out);
        end else begin
          e = exp_q.pop_front();
          if (pc_out !== e.pc || inst_out !== e.inst) begin
            n_fail++;
            $display("FAIL stream_data: got %h/%h want %h/%h", pc_out, inst_out, e.pc, e.inst);
          end
        end
      end
      if (i == 8) imem_req_ready = 1'b0;
      cycle();
    end
    n_tests++;
    if (exp_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL stream_issue_count: next addr %h want 0000000c", exp_addr);
    end
  endtask

  task automatic test_pause();
    exp_t e;
    redirect = 1'b1;
    redirect_pc = 32'h10;
    cycle();
    redirect = 1'b0;
    use_override = 1'b1;
    override_word = 32'h00A0_0093;
    imem_req_ready = 1'b1;
    pause = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    n_tests++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL pause_sb_size: got %0d want 1", exp_q.size());
    end else begin
      e = exp_q[0];
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (inst_valid !== 1'b1 || inst_out !== 32'h00A0_0093 || pc_out !== 32'h10 || imem_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL pause_hold_c%0d: v=%b inst=%h pc=%h req=%b", k, inst_valid, inst_out, pc_out, imem_req_valid);
        end
        cycle();
      end
      pause = 1'b0;
      n_tests++;
      e = exp_q.pop_front();
      if (inst_valid !== 1'b1 || pc_out !== e.pc || inst_out !== e.inst) begin
        n_fail++;
        $display("FAIL pause_release: v=%b got %h/%h want %h/%h", inst_valid, pc_out, inst_out, e.pc, e.inst);
      end
      cycle();
      n_tests++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h14) begin
        n_fail++;
        $display("FAIL pause_next_addr: req=%b addr=%h want 1/00000014", imem_req_valid, imem_addr);
      end
    end
    use_override = 1'b0;
  endtask

  task automatic test_redirect_wait();
    exp_t e;
    mem_delay = 3;
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0;
    n_tests++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_drop_idle: req=%b v=%b want 0/0", imem_req_valid, inst_valid);
    end
    cycle();
    // The late response belongs to the flushed stream.
    exp_q.delete();
    n_tests++;
    if (imem_req_valid !== 1'b0 || imem_resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_resp_cycle: req=%b resp=%b want 0/1", imem_req_valid, imem_resp_valid);
    end
    cycle();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_new_req: req=%b addr=%h v=%b want 1/00000200/0", imem_req_valid, imem_addr, inst_valid);
    end
    mem_delay = 1;
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rdw_sb_empty: got v=%b want a pending entry", inst_valid);
    end else begin
      e = exp_q.pop_front();
      if (inst_valid !== 1'b1 || pc_out !== e.pc || e.pc !== 32'h200 || inst_out !== e.inst) begin
        n_fail++;
        $display("FAIL rdw_first_valid: v=%b got %h/%h want 00000200/%h", inst_valid, pc_out, inst_out, e.inst);
      end
    end
    cycle();
  endtask

  task automatic test_redirect_hold();
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    n_tests++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h204) begin
      n_fail++;
      $display("FAIL rdh_hold: v=%b pc=%h want 1/00000204", inst_valid, pc_out);
    end
    redirect = 1'b1;
    redirect_pc = 32'h300;
    pause = 1'b0;
    cycle();
    redirect = 1'b0;
    exp_q.delete();
    n_tests++;
    if (inst_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL rdh_discard: v=%b inst=%h pc=%h req=%b addr=%h want 0/%h/0/1/00000300",
               inst_valid, inst_out, pc_out, imem_req_valid, imem_addr, NOP);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL wrap_sb_empty: got v=%b want a pending entry", inst_valid);
    end else begin
      e = exp_q.pop_front();
      if (inst_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || inst_out !== e.inst) begin
        n_fail++;
        $display("FAIL wrap_present: v=%b got %h/%h want fffffffc/%h", inst_valid, pc_out, inst_out, e.inst);
      end
    end
    cycle();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: req=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_reset_hold();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    pause = 1'b1;
    cycle();
    cycle();
    n_tests++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h40) begin
      n_fail++;
      $display("FAIL rsth_hold: v=%b pc=%h want 1/00000040", inst_valid, pc_out);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    n_tests++;
    if (inst_valid !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rsth_after: v=%b inst=%h pc=%h req=%b addr=%h", inst_valid, inst_out, pc_out, imem_req_valid, imem_addr);
    end
    pause = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    cycle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
        n_fail++;
        $display("FAIL rsth_stray_c%0d: v=%b req=%b addr=%h want 0/1/%h", k, inst_valid, imem_req_valid, imem_addr, RST_PC);
      end
      cycle();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_pause();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning PC and address width.
REQ-002 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state updates on posedge clock.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port pause, input, 1, meaning downstream cannot accept the presented instruction this cycle.
REQ-006 The module SHALL have port redirect, input, 1, meaning branch/jump taken and the fetch stream is flushed.
REQ-007 The module SHALL have port redirect_pc, input, XLEN, the new fetch address, sampled when redirect=1.
REQ-008 The module SHALL have port imem_req_valid, output, 1, the fetch request.
REQ-009 The module SHALL have port imem_req_ready, input, 1; a request is accepted on a cycle with imem_req_valid && imem_req_ready.
REQ-010 The module SHALL have port imem_addr, output, XLEN, the fetch address.
REQ-011 The module SHALL have port imem_resp_valid, input, 1, the response strobe; it arrives at least 1 cycle after acceptance.
REQ-012 The module SHALL have port imem_resp_data, input, 32, the instruction word.
REQ-013 The module SHALL have port pc_out, output, XLEN, the PC of the presented instruction, feeding the IF/ID register.
REQ-014 The module SHALL have port inst_out, output, 32, the presented instruction, feeding the IF/ID register.
REQ-015 The module SHALL have port inst_valid, output, 1, high when pc_out/inst_out are real; the top level drives the IF/ID bubble with ~inst_valid.

Function
REQ-016 The module SHALL be an FSM with states FETCH, WAIT, HOLD and DROP, and at most one outstanding request.
REQ-017 imem_req_valid SHALL equal (state==FETCH); imem_addr SHALL equal the pc register at all times.
REQ-018 FETCH: on acceptance the FSM SHALL go to WAIT; otherwise it SHALL stay in FETCH.
REQ-019 WAIT: on imem_resp_valid the module SHALL capture imem_resp_data and pc into a holding buffer and go to HOLD.
REQ-020 HOLD: inst_valid=1, inst_out=buffer, pc_out=buffered pc; if pause=0, the instruction is consumed this cycle, pc <= pc+4, and the FSM goes to FETCH; if pause=1, the FSM stays in HOLD with outputs held stable.
REQ-021 When inst_valid=0, inst_out SHALL be NOP 0x00000013 and pc_out SHALL be 0.
REQ-022 Minimum latency SHALL be: request accepted at cycle T, response at T+1, inst_valid=1 at T+2.
REQ-023 redirect SHALL take priority over pause and over consumption: pc <= {redirect_pc[XLEN-1:2], 2'b00} (low 2 bits ignored), and any held instruction SHALL be discarded (inst_valid=0 next cycle).
REQ-024 Redirect next-state in FETCH with acceptance the same cycle SHALL be DROP; in FETCH without acceptance, FETCH.
REQ-025 Redirect next-state in WAIT with imem_resp_valid the same cycle SHALL be FETCH (response discarded); in WAIT without imem_resp_valid, DROP.
REQ-026 Redirect next-state in HOLD SHALL be FETCH; in DROP, DROP (pc updated).
REQ-027 DROP SHALL have imem_req_valid=0; on imem_resp_valid the response SHALL be discarded and the FSM goes to FETCH.
REQ-028 pc+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
REQ-029 imem_resp_valid in FETCH or HOLD (no outstanding request) SHALL be ignored.

Reset
REQ-030 reset=1 at a clock edge SHALL set pc=RESET_PC, state=FETCH and the buffer to NOP/0, overriding redirect, pause and any in-flight request.
REQ-031 During and after reset: inst_valid=0, inst_out=0x00000013, pc_out=0; imem_req_valid=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-032 A response to a request accepted before reset SHALL NOT be presented; reset mid-WAIT SHALL go to FETCH and the memory is required to be reset together with this block.

Verification
REQ-033 Reset, ready=1, responses at +1 cycle with pause=0 -> addresses 0,4,8 issued; inst_valid pulses every 3 cycles with matching pc_out.
REQ-034 Response 0x00A00093 at pc 0x10 with pause=1 held for 4 cycles -> inst_out/pc_out stable for 4 cycles; next request addr 0x14 only after pause drops.
REQ-035 Redirect to 0x203 while in WAIT, response arrives 2 cycles later -> response dropped, next request addr 0x200, first valid pc_out=0x200.
REQ-036 Redirect same cycle as HOLD with pause=0 -> held instruction discarded (inst_valid=0), pc=redirect target, not pc+4.
REQ-037 pc=0xFFFFFFFC consumed -> next imem_addr=0x00000000.
REQ-038 reset asserted in HOLD with pause=1 -> next cycle inst_valid=0, imem_addr=RESET_PC, a late stray response ignored.
